// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one registered ALU between two requesters.
// Latency: response valid ALU_LATENCY+1 edges after the accept edge; one operation in flight.
// Backpressure: requests are refused outside IDLE; a response is held until its owner takes it.
module alu_arbiter #(
    parameter int ALU_LATENCY = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID_0,
    output logic       REQ_READY_0,
    input  logic [7:0] REQ_A_0,
    input  logic [7:0] REQ_B_0,
    input  logic [3:0] REQ_OP_0,
    output logic       RSP_VALID_0,
    input  logic       RSP_READY_0,
    output logic [7:0] RSP_DATA_0,
    input  logic       REQ_VALID_1,
    output logic       REQ_READY_1,
    input  logic [7:0] REQ_A_1,
    input  logic [7:0] REQ_B_1,
    input  logic [3:0] REQ_OP_1,
    output logic       RSP_VALID_1,
    input  logic       RSP_READY_1,
    output logic [7:0] RSP_DATA_1,
    output logic [7:0] ALU_IN_A,
    output logic [7:0] ALU_IN_B,
    output logic [3:0] ALU_OP,
    input  logic [7:0] ALU_RESULT,
    output logic       BUSY
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXEC    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;
    localparam logic [3:0] CNT_INIT  = 4'(ALU_LATENCY - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [7:0] rsp_data0_q, rsp_data0_d;
    logic [7:0] rsp_data1_q, rsp_data1_d;
    logic       rsp_vld0_q, rsp_vld0_d;
    logic       rsp_vld1_q, rsp_vld1_d;

    logic       grant0, grant1, idle, accept, winner;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        idle   = (state_q == S_IDLE);
        grant0 = REQ_VALID_0 && (!REQ_VALID_1 || last_grant_q);
        grant1 = REQ_VALID_1 && (!REQ_VALID_0 || !last_grant_q);
        accept = idle && (grant0 || grant1);
        winner = grant1;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_data0_d  = rsp_data0_q;
        rsp_data1_d  = rsp_data1_q;
        rsp_vld0_d   = rsp_vld0_q;
        rsp_vld1_d   = rsp_vld1_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_a_d      = winner ? REQ_A_1  : REQ_A_0;
                    alu_b_d      = winner ? REQ_B_1  : REQ_B_0;
                    alu_op_d     = winner ? REQ_OP_1 : REQ_OP_0;
                    owner_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = CNT_INIT;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                if (owner_q) begin
                    rsp_data1_d = ALU_RESULT;
                    rsp_vld1_d  = 1'b1;
                end else begin
                    rsp_data0_d = ALU_RESULT;
                    rsp_vld0_d  = 1'b1;
                end
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                // Only the owner's ready matters; the other side never sees valid.
                if (owner_q ? RSP_READY_1 : RSP_READY_0) begin
                    rsp_vld0_d = 1'b0;
                    rsp_vld1_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            alu_op_q     <= 4'd0;
            rsp_data0_q  <= 8'd0;
            rsp_data1_q  <= 8'd0;
            rsp_vld0_q   <= 1'b0;
            rsp_vld1_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_data0_q  <= rsp_data0_d;
            rsp_data1_q  <= rsp_data1_d;
            rsp_vld0_q   <= rsp_vld0_d;
            rsp_vld1_q   <= rsp_vld1_d;
        end
    end

    assign REQ_READY_0 = idle && grant0;
    assign REQ_READY_1 = idle && grant1;
    assign RSP_VALID_0 = rsp_vld0_q;
    assign RSP_VALID_1 = rsp_vld1_q;
    assign RSP_DATA_0  = rsp_data0_q;
    assign RSP_DATA_1  = rsp_data1_q;
    assign ALU_IN_A    = alu_a_q;
    assign ALU_IN_B    = alu_b_q;
    assign ALU_OP      = alu_op_q;
    assign BUSY        = !idle;

endmodule
